// File: rtl/dm_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// byte-enable width and the byte-merge helper used by the store path.
package dm_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int DEFAULT_WAIT_CYCLES = 2;
   localparam int BE_W                = 4;

   // Replace each enabled byte lane of old_word with the matching lane of new_word.
   function automatic logic [31:0] merge_bytes(input logic [31:0]     old_word,
                                               input logic [31:0]     new_word,
                                               input logic [BE_W-1:0] be);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < BE_W; i++) begin
         if (be[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Request/response bundle between the memory stage (master) and the responder (slave),
// plus a write-trace side channel describing each performed store.
interface dm_responder_if #(
   parameter int ADDR_W = 12
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [3:0]        req_be;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [31:0]       req_pc;
   logic              rsp_valid;
   logic              rsp_we;
   logic [31:0]       rsp_rdata;
   logic              busy;
   logic              trace_valid;
   logic [31:0]       trace_pc;
   logic [ADDR_W+1:0] trace_addr;
   logic [31:0]       trace_data;

   modport master (
      output req_valid, req_we, req_be, req_addr, req_wdata, req_pc,
      input  req_ready, rsp_valid, rsp_we, rsp_rdata, busy,
      input  trace_valid, trace_pc, trace_addr, trace_data
   );

   modport slave (
      input  req_valid, req_we, req_be, req_addr, req_wdata, req_pc,
      output req_ready, rsp_valid, rsp_we, rsp_rdata, busy,
      output trace_valid, trace_pc, trace_addr, trace_data
   );
endinterface

// File: rtl/dm_responder_array.sv
// Single-port word RAM with per-byte write enables; synchronous write and read-before-write
// synchronous read. Only the read register is reset, never the contents.
module dm_array
   import dm_responder_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              we,
   input  logic [BE_W-1:0]   be,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem_r [2**ADDR_W];

   // Byte-lane writes on an enabled store access.
   always_ff @(posedge clk) begin
      if (en && we) begin
         for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
               mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   // Read register captures the pre-write word on every access and holds it otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= 32'h0;
      end else if (en) begin
         rdata <= mem_r[addr];
      end
   end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one outstanding word access at a time with WAIT_CYCLES of modelled
// latency, byte-enabled stores and a single-cycle response pulse.
module dm_responder
   import dm_responder_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
   input logic           clk,
   input logic           reset,
   dm_responder_if.slave bus
);

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t            state_r;
   logic [3:0]        cnt_r;
   logic              we_r;
   logic [BE_W-1:0]   be_r;
   logic [ADDR_W-1:0] addr_r;
   logic [31:0]       wdata_r;
   logic [31:0]       pc_r;
   logic              rsp_valid_r;
   logic              rsp_we_r;
   logic              ready_r;
   logic              busy_r;
   logic              access_s;
   logic [31:0]       ram_rdata_s;

   assign access_s = (state_r == ST_WAIT) && (cnt_r == 4'd0);

   dm_array #(.ADDR_W(ADDR_W)) u_array (
      .clk   (clk),
      .rst_n (reset),
      .en    (access_s),
      .we    (we_r),
      .be    (be_r),
      .addr  (addr_r),
      .wdata (wdata_r),
      .rdata (ram_rdata_s)
   );

   // Request FSM with capture registers and registered handshake/response flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 4'd0;
         we_r        <= 1'b0;
         be_r        <= '0;
         addr_r      <= '0;
         wdata_r     <= 32'h0;
         pc_r        <= 32'h0;
         rsp_valid_r <= 1'b0;
         rsp_we_r    <= 1'b0;
         ready_r     <= 1'b1;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  we_r    <= bus.req_we;
                  be_r    <= bus.req_be;
                  addr_r  <= bus.req_addr;
                  wdata_r <= bus.req_wdata;
                  pc_r    <= bus.req_pc;
                  cnt_r   <= WAIT_INIT;
                  ready_r <= 1'b0;
                  busy_r  <= 1'b1;
                  state_r <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt_r == 4'd0) begin
                  rsp_valid_r <= 1'b1;
                  rsp_we_r    <= we_r;
                  state_r     <= ST_RESP;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            ST_RESP: begin
               rsp_valid_r <= 1'b0;
               ready_r     <= 1'b1;
               busy_r      <= 1'b0;
               state_r     <= ST_IDLE;
            end
            default: begin
               rsp_valid_r <= 1'b0;
               ready_r     <= 1'b1;
               busy_r      <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   // Store responses read as zero; loads hold the RAM read register until the next access.
   assign bus.req_ready = ready_r;
   assign bus.busy      = busy_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_we    = rsp_we_r;
   assign bus.rsp_rdata = rsp_we_r ? 32'h0 : ram_rdata_s;

   // The RAM returned the pre-store word, so the merged word is rebuilt during RESP.
   assign bus.trace_valid = (state_r == ST_RESP) && we_r && (be_r != '0);
   assign bus.trace_pc    = pc_r;
   assign bus.trace_addr  = {addr_r, 2'b00};
   assign bus.trace_data  = merge_bytes(ram_rdata_s, wdata_r, be_r);

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: vector table, multi-cycle corner sequences and
// randomized traffic against a word-array reference model.
module tb_dm_responder;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dm_responder_if #(.ADDR_W(12)) bus ();
   dm_responder_if #(.ADDR_W(12)) bus0 ();

   dm_responder #(.ADDR_W(12), .WAIT_CYCLES(2)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   dm_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] model [int];

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] apply_store(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] be);
      logic [31:0] keep;
      keep = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (old & ~keep) | (wd & keep);
   endfunction

   function automatic logic [31:0] model_rd(input logic [11:0] addr);
      if (model.exists(int'(addr))) return model[int'(addr)];
      return 32'h0;
   endfunction

   // One full transaction on the WAIT_CYCLES=2 instance, checked against the model.
   task automatic run_one(input logic we, input logic [3:0] be, input logic [11:0] addr,
                          input logic [31:0] wdata, input logic [31:0] pc, output logic [31:0] got);
      int lat, busy_cyc, k;
      logic rwe, tv;
      logic [31:0] td, tp, exp_rd, newv;
      logic [13:0] ta;
      k = 0;
      while (!bus.req_ready && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("ready_before_req", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_be    = be;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_pc    = pc;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_we    = 1'($urandom);
      bus.req_be    = 4'($urandom);
      bus.req_addr  = 12'($urandom);
      bus.req_wdata = $urandom;
      bus.req_pc    = $urandom;
      lat = -1; busy_cyc = 0; got = 32'h0; rwe = 1'b0; tv = 1'b0; td = 32'h0; tp = 32'h0; ta = 14'h0;
      for (int j = 0; j < 40; j++) begin
         if (bus.busy) busy_cyc++;
         if (bus.rsp_valid) begin
            if (lat < 0) begin
               lat = j;
               got = bus.rsp_rdata;
               rwe = bus.rsp_we;
               tv  = bus.trace_valid;
               td  = bus.trace_data;
               tp  = bus.trace_pc;
               ta  = bus.trace_addr;
            end else begin
               lat = 100;
            end
         end
         if (lat >= 0 && !bus.busy) break;
         @(negedge clk);
      end
      check("rsp_latency", 32'(lat), 32'd3);
      check("busy_cycles", 32'(busy_cyc), 32'd4);
      check("rsp_we", 32'(rwe), 32'(we));
      check("rsp_valid_single", 32'(bus.rsp_valid), 32'd0);
      exp_rd = we ? 32'h0 : model_rd(addr);
      check("rsp_rdata", got, exp_rd);
      if (we) begin
         newv = apply_store(model_rd(addr), wdata, be);
         model[int'(addr)] = newv;
         check("trace_valid", 32'(tv), (be != 4'h0) ? 32'd1 : 32'd0);
         if (be != 4'h0) begin
            check("trace_data", td, newv);
            check("trace_pc", tp, pc);
            check("trace_addr", 32'(ta), 32'({addr, 2'b00}));
         end
      end
   endtask

   initial begin
      logic [31:0] got, pc, exp_a, exp_b;
      logic [11:0] addr;
      logic [3:0] be;
      logic we;
      int acc [$];
      logic [31:0] rd [$];

      reset = 1'b0;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_be = 4'h0; bus.req_addr = 12'h0;
      bus.req_wdata = 32'h0; bus.req_pc = 32'h0;
      bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_be = 4'h0; bus0.req_addr = 12'h0;
      bus0.req_wdata = 32'h0; bus0.req_pc = 32'h0;
      repeat (3) @(negedge clk);
      check("reset_busy_low", 32'(bus.busy), 32'd0);
      check("reset_rsp_valid_low", 32'(bus.rsp_valid), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("post_reset_ready", 32'(bus.req_ready), 32'd1);
      check("post_reset_busy", 32'(bus.busy), 32'd0);
      check("post_reset_rsp_we", 32'(bus.rsp_we), 32'd0);
      check("post_reset_rdata", bus.rsp_rdata, 32'h0);
      check("post_reset_ready0", 32'(bus0.req_ready), 32'd1);

      // Zero the working set so model and array agree regardless of simulator init.
      for (int a = 0; a < 16; a++) run_one(1'b1, 4'hF, 12'(a), 32'h0, 32'h100 + 32'(a), got);

      vecs[0]  = '{1'b1, 4'hF, 12'h010, 32'h1234_5678, 32'h0};
      vecs[1]  = '{1'b0, 4'h0, 12'h010, 32'h0,         32'h1234_5678};
      vecs[2]  = '{1'b1, 4'h4, 12'h010, 32'h00AB_0000, 32'h0};
      vecs[3]  = '{1'b0, 4'hF, 12'h010, 32'hFFFF_FFFF, 32'h12AB_5678};
      vecs[4]  = '{1'b1, 4'hF, 12'h003, 32'h0000_00FF, 32'h0};
      vecs[5]  = '{1'b1, 4'h0, 12'h003, 32'hFFFF_FFFF, 32'h0};
      vecs[6]  = '{1'b0, 4'h0, 12'h003, 32'h0,         32'h0000_00FF};
      vecs[7]  = '{1'b1, 4'hF, 12'h007, 32'h1122_3344, 32'h0};
      vecs[8]  = '{1'b1, 4'h3, 12'h007, 32'hAAAA_5555, 32'h0};
      vecs[9]  = '{1'b0, 4'h0, 12'h007, 32'h0,         32'h1122_5555};
      vecs[10] = '{1'b1, 4'hF, 12'hFFF, 32'h0,         32'h0};
      vecs[11] = '{1'b1, 4'h8, 12'hFFF, 32'h9900_0000, 32'h0};
      vecs[12] = '{1'b0, 4'h0, 12'hFFF, 32'h0,         32'h9900_0000};
      vecs[13] = '{1'b1, 4'h6, 12'h007, 32'h00FF_FF00, 32'h0};
      vecs[14] = '{1'b0, 4'h0, 12'h007, 32'h0,         32'h11FF_FF55};
      for (int i = 0; i < 15; i++) begin
         run_one(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, 32'h4000 + 32'(4 * i), got);
         check($sformatf("vec%0d_rdata", i), got, vecs[i].exp_rdata);
      end

      // Back-to-back loads with req_valid held high: second accept only after RESP.
      exp_a = model_rd(12'h003);
      exp_b = model_rd(12'h007);
      bus.req_we = 1'b0; bus.req_be = 4'h0; bus.req_addr = 12'h003; bus.req_valid = 1'b1;
      for (int n = 0; n < 16; n++) begin
         if (acc.size() == 1) bus.req_addr = 12'h007;
         if (acc.size() == 2) bus.req_valid = 1'b0;
         if (bus.req_valid && bus.req_ready) acc.push_back(n);
         if (bus.rsp_valid) rd.push_back(bus.rsp_rdata);
         @(negedge clk);
      end
      bus.req_valid = 1'b0;
      check("held_valid_accepts", 32'(acc.size()), 32'd2);
      check("held_valid_spacing", (acc.size() >= 2) ? 32'(acc[1] - acc[0]) : 32'hFFFF_FFFF, 32'd5);
      check("held_valid_pulses", 32'(rd.size()), 32'd2);
      check("held_valid_rd0", (rd.size() >= 1) ? rd[0] : 32'hDEAD_0000, exp_a);
      check("held_valid_rd1", (rd.size() >= 2) ? rd[1] : 32'hDEAD_0001, exp_b);

      // Reset during WAIT drops the pending store to word 5.
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_be = 4'hF; bus.req_addr = 12'h005;
      bus.req_wdata = 32'hDEAD_BEEF; bus.req_pc = 32'h8000;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midwait_reset_ready", 32'(bus.req_ready), 32'd1);
      check("midwait_reset_busy", 32'(bus.busy), 32'd0);
      check("midwait_reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      run_one(1'b0, 4'h0, 12'h005, 32'h0, 32'h8004, got);
      check("midwait_reset_word5", got, 32'h0);

      // Randomized traffic over a small address window.
      for (int t = 0; t < 80; t++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         addr = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
         we   = 1'($urandom);
         be   = 4'($urandom);
         pc   = $urandom;
         run_one(we, be, addr, $urandom, pc, got);
      end

      // WAIT_CYCLES=0 instance: preload last word, then load it back.
      bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_be = 4'hF; bus0.req_addr = 12'hFFF;
      bus0.req_wdata = 32'hCAFE_F00D;
      @(negedge clk);
      bus0.req_valid = 1'b0;
      check("w0_store_no_early_rsp", 32'(bus0.rsp_valid), 32'd0);
      @(negedge clk);
      check("w0_store_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
      check("w0_store_rsp_we", 32'(bus0.rsp_we), 32'd1);
      @(negedge clk);
      check("w0_ready_again", 32'(bus0.req_ready), 32'd1);
      bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_be = 4'h0; bus0.req_wdata = 32'h0;
      @(negedge clk);
      bus0.req_valid = 1'b0;
      check("w0_load_no_early_rsp", 32'(bus0.rsp_valid), 32'd0);
      @(negedge clk);
      check("w0_load_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
      check("w0_load_rdata", bus0.rsp_rdata, 32'hCAFE_F00D);
      check("w0_load_rsp_we", 32'(bus0.rsp_we), 32'd0);
      @(negedge clk);
      check("w0_rsp_single_pulse", 32'(bus0.rsp_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
